// File: rtl/maxpool_if.sv
// ---------------------------------------------------------------------------
// maxpool_if
// Stream bundle for the max-pool stage: an input sample stream (x_*) and an
// output result stream (y_*), both valid/ready.
//   x_data  [T]  signed input sample        x_valid / x_ready : input handshake
//   y_data  [T]  signed pooled max          y_valid / y_ready : output handshake
// Modports:
//   slave  : the pool stage (consumes x, produces y)
//   master : the environment around it (produces x, consumes y)
// ---------------------------------------------------------------------------
interface maxpool_if #(
   parameter int T = 16
);
   logic [T-1:0] x_data;
   logic         x_valid;
   logic         x_ready;
   logic [T-1:0] y_data;
   logic         y_valid;
   logic         y_ready;

   modport slave (
      input  x_data, x_valid, y_ready,
      output x_ready, y_data, y_valid
   );

   modport master (
      output x_data, x_valid, y_ready,
      input  x_ready, y_data, y_valid
   );
endinterface

// File: rtl/maxpool_stage.sv
// ---------------------------------------------------------------------------
// maxpool_stage
// Streaming 1-D max-pool: emits the signed maximum of each non-overlapping
// window of POOL samples within a vector of SIZE_IN samples. Samples past the
// last whole window of a vector are accepted and dropped. Results go through
// a 2-entry FIFO with a registered head so the output tolerates back-pressure
// while input still flows at one sample per cycle.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; clears all window state and the FIFO
//   bus    : maxpool_if.slave (x_data/x_valid/x_ready in, y_data/y_valid/y_ready out)
// ---------------------------------------------------------------------------
module maxpool_stage #(
   parameter int T       = 16,
   parameter int POOL    = 2,
   parameter int SIZE_IN = 64
) (
   input  logic      clk,
   input  logic      reset,
   maxpool_if.slave  bus
);
   localparam int NUM_OUT = SIZE_IN / POOL;
   localparam int LIMIT   = NUM_OUT * POOL;
   // One extra count of headroom so LIMIT (which may equal SIZE_IN) fits.
   localparam int IW      = $clog2(SIZE_IN + 1);
   localparam int WW      = $clog2(POOL);

   localparam logic [IW-1:0] IN_LAST  = IW'(SIZE_IN - 1);
   localparam logic [IW-1:0] IN_LIMIT = IW'(LIMIT);
   localparam logic [WW-1:0] WIN_LAST = WW'(POOL - 1);

   logic [IW-1:0]       in_cnt_reg,  in_cnt_next;
   logic [WW-1:0]       win_cnt_reg, win_cnt_next;
   logic signed [T-1:0] acc_reg,     acc_next;
   logic signed [T-1:0] head_reg,    head_next;
   logic signed [T-1:0] tail_reg,    tail_next;
   logic [1:0]          count_reg,   count_next;

   logic signed [T-1:0] x_s;
   logic signed [T-1:0] max_val;
   logic                accept;
   logic                pop;
   logic                push;

   assign x_s = $signed(bus.x_data);

   // Ready depends only on the registered occupancy, so it never forms a
   // combinational path from y_ready or x_valid.
   assign bus.x_ready = ~reset & (count_reg != 2'd2);
   assign bus.y_valid = (count_reg != 2'd0);
   assign bus.y_data  = bus.y_valid ? head_reg : '0;

   assign accept = bus.x_valid & bus.x_ready;
   assign pop    = bus.y_valid & bus.y_ready;

   // Ties keep the accumulator; the value is the same either way.
   assign max_val = (x_s > acc_reg) ? x_s : acc_reg;

   assign push = accept && (in_cnt_reg < IN_LIMIT) && (win_cnt_reg == WIN_LAST);

   // Window and vector position tracking.
   always_comb begin
      in_cnt_next  = in_cnt_reg;
      win_cnt_next = win_cnt_reg;
      acc_next     = acc_reg;
      if (accept) begin
         if (in_cnt_reg < IN_LIMIT) begin
            if (win_cnt_reg == '0) begin
               acc_next     = x_s;
               win_cnt_next = win_cnt_reg + WW'(1);
            end else if (win_cnt_reg == WIN_LAST) begin
               win_cnt_next = '0;
            end else begin
               acc_next     = max_val;
               win_cnt_next = win_cnt_reg + WW'(1);
            end
         end
         // Last sample of the vector realigns the window for the next one.
         if (in_cnt_reg == IN_LAST) begin
            in_cnt_next  = '0;
            win_cnt_next = '0;
         end else begin
            in_cnt_next = in_cnt_reg + IW'(1);
         end
      end
   end

   // Two-entry FIFO with the head held in its own register so y_data comes
   // straight from a flop.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      case ({push, pop})
         2'b10: begin
            if (count_reg == 2'd0) head_next = max_val;
            else                   tail_next = max_val;
            count_next = count_reg + 2'd1;
         end
         2'b01: begin
            head_next  = tail_reg;
            count_next = count_reg - 2'd1;
         end
         2'b11: begin
            // Occupancy stays put; the new result slots in behind the head.
            if (count_reg == 2'd1) begin
               head_next = max_val;
            end else begin
               head_next = tail_reg;
               tail_next = max_val;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_cnt_reg  <= '0;
         win_cnt_reg <= '0;
         acc_reg     <= '0;
         head_reg    <= '0;
         tail_reg    <= '0;
         count_reg   <= '0;
      end else begin
         in_cnt_reg  <= in_cnt_next;
         win_cnt_reg <= win_cnt_next;
         acc_reg     <= acc_next;
         head_reg    <= head_next;
         tail_reg    <= tail_next;
         count_reg   <= count_next;
      end
   end
endmodule
